gpio_periph: RTL
================

# gpio_periph

Parametrised memory-mapped GPIO peripheral for the single-cycle processor system. It replaces the fixed switch/button/LED glue in `top` with a word-addressed register block on the data-memory bus. Inputs are synchronised and buttons are debounced per channel. Press events latch into a sticky status register that can raise an interrupt line.

## Interface
Parameters:
- `SW_W`, default 10: switch input width.
- `LED_W`, default 10: LED output width.
- `NBTN`, default 4: number of button channels, 1..32.
- `DEB_CYCLES`, default 50: consecutive stable cycles needed to accept a button change, at least 2.

Ports:
- `clk`  in  1: the only clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `switches`  in  SW_W: raw, asynchronous slide switches.
- `buttons`  in  NBTN: raw, asynchronous, active-low (1 = released).
- `addr`  in  32: bus byte address. Only bits [4:2] are decoded; the caller gates chip-select into `we`.
- `we`  in  1: write strobe.
- `wdata`  in  32: write data.
- `rdata`  out  32: read data, combinational from `addr` and the registers.
- `leds`  out  LED_W: LED drive, equal to the LED register.
- `irq`  out  1: level interrupt, `|(evt & ien)`, driven from registers only.

## Operation
- Register map (word index = `addr[4:2]`). Unmapped indices read 0; writes to them are ignored.
  - 0 SW, RO: synchronised switches, zero-extended.
  - 1 LED, RW: `LED_W` bits; upper write bits are dropped.
  - 2 BTN, RO: debounced level, 1 = pressed.
  - 3 EVT, RO/W1C: sticky press events.
  - 4 IEN, RW: `NBTN`-bit interrupt enable.
- Synchronisers: two flops per input bit.
  - Switch flops reset to 0.
  - Button flops reset to 1 (released).
- Debouncer, per button channel, with stable state `st` (1 = released, reset 1) and counter `cnt` (reset 0, width `$clog2(DEB_CYCLES+1)`):
  - Synchronised input equal to `st`: `cnt` <= 0.
  - Input differs and `cnt == DEB_CYCLES-1`: `st` <= input and `cnt` <= 0.
  - Input differs otherwise: `cnt` increments.
  - A single agreeing cycle restarts the count. A glitch shorter than `DEB_CYCLES` cycles never changes `st`.
- BTN register reads `~st`.
- Event logic:
  - `st` going 1→0 (press accepted) sets `evt[i]` on the same edge that updates `st`.
  - Releases set nothing.
- EVT write: each `wdata[i]=1` clears `evt[i]`; 0 bits leave it unchanged. If a set and a clear of the same bit hit the same edge, the set wins and the bit stays 1.
- IEN and LED are plain registers, both reset to 0. `irq` is 0 after reset.
- Reset mid-operation:
  - All counters, synchronisers, `st`, `evt`, `ien` and LED return to their reset values on that edge.
  - A button still held afterwards is treated as a fresh change and needs the full `DEB_CYCLES` again.

## Timing
- Switch change to SW readback: 2 edges.
- Button press to BTN/EVT set: 2 + `DEB_CYCLES` edges, provided the input is held steady.
- `irq` follows EVT/IEN with no extra latency. It deasserts on the edge where the W1C write or the IEN write takes effect.
- Writes take effect on the `clk` edge with `we=1`. A read in the same cycle returns the old value.
- `rdata` is combinational, so there are zero read wait states.
- `leds` changes on the write edge.

## Test plan
- Reset values: hold `reset=1` for 2 cycles with `buttons=4'hF` → `leds=0`, `irq=0`, and reads of indices 0–7 all return 0 (switches=0).
- Switch read and LED write:
  - `switches=10'd4` → read index 0 returns 0x4 from the 2nd edge on, not before.
  - Write index 1 with 0xFFFF_FFFF → `leds=10'h3FF`, and readback returns 0x3FF.
- Glitch rejection: with `DEB_CYCLES=50`, drive `buttons[0]=0` for 30 cycles, then 1 → BTN=0 and EVT=0 throughout.
- Accepted press and interrupt:
  - IEN=0x1; hold `buttons[0]=0` → BTN and EVT read 0x1 exactly 52 edges after the drop, and `irq=1` on that edge.
  - Hold `buttons[0]=0` with IEN=0 → EVT=0x1 but `irq=0`.
- W1C and collision:
  - Write EVT with 0x1 → EVT=0 and `irq=0` next cycle.
  - Time a W1C to bit 1 on the same edge button 1's press is accepted → EVT bit 1 stays 1.
- Reset mid-debounce: press `buttons[2]` for 40 cycles, pulse `reset` for 1 cycle while still pressed → BTN bit 2 sets 52 edges after reset deasserts, not earlier.

Source files
------------

// File: rtl/gpio_periph.sv
// Memory-mapped GPIO block: synchronised switches, LED register, per-channel
// debounced active-low buttons, sticky press events (W1C), interrupt enable.
// Word map on addr[4:2]: 0 SW, 1 LED, 2 BTN, 3 EVT, 4 IEN; other indices read 0.
// Bus handshake: there is no valid/ready pair; a write is accepted on every
// rising clk edge where we=1, and rdata is valid combinationally in the same
// cycle that addr is presented (zero wait states, old value during a write).
module gpio_periph #(
  parameter int SW_W       = 10,
  parameter int LED_W      = 10,
  parameter int NBTN       = 4,
  parameter int DEB_CYCLES = 50
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SW_W-1:0]   switches,
  input  logic [NBTN-1:0]   buttons,
  input  logic [31:0]       addr,
  input  logic              we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [LED_W-1:0]  leds,
  output logic              irq
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [SW_W-1:0]  sw_s1, sw_s2;
  logic [NBTN-1:0]  btn_s1, btn_s2;
  logic [NBTN-1:0]  st, st_nxt, press;
  logic [CW-1:0]    cnt     [NBTN];
  logic [CW-1:0]    cnt_nxt [NBTN];
  logic [NBTN-1:0]  evt, ien, evt_clr;
  logic [LED_W-1:0] led;
  logic [2:0]       idx;
  logic             wr_led, wr_evt, wr_ien;
  logic             unused_bits;

  assign idx    = addr[4:2];
  assign wr_led = we && (idx == 3'd1);
  assign wr_evt = we && (idx == 3'd3);
  assign wr_ien = we && (idx == 3'd4);

  // Only addr[4:2] and the low wdata bits carry meaning; the rest is ignored.
  assign unused_bits = ^{addr[31:5], addr[1:0], wdata};

  // Two-flop synchronisers; buttons idle high (released).
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '1;
      btn_s2 <= '1;
    end else begin
      sw_s1  <= switches;
      sw_s2  <= sw_s1;
      btn_s1 <= buttons;
      btn_s2 <= btn_s1;
    end
  end

  // Debounce next-state: any agreeing cycle clears the count; DEB_CYCLES
  // consecutive differing cycles are needed before the stable state flips.
  always_comb begin
    for (int i = 0; i < NBTN; i++) begin
      st_nxt[i]  = st[i];
      cnt_nxt[i] = '0;
      if (btn_s2[i] != st[i]) begin
        if (cnt[i] == CNT_MAX) st_nxt[i] = btn_s2[i];
        else                   cnt_nxt[i] = cnt[i] + CW'(1);
      end
    end
  end

  // A press is an accepted 1->0 transition of the stable state.
  assign press   = st & ~st_nxt;
  assign evt_clr = wr_evt ? wdata[NBTN-1:0] : '0;

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= '1;
      for (int i = 0; i < NBTN; i++) cnt[i] <= '0;
    end else begin
      st <= st_nxt;
      for (int i = 0; i < NBTN; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  // Sticky events: set wins over a W1C clear on the same edge.
  always_ff @(posedge clk) begin
    if (reset) evt <= '0;
    else       evt <= (evt & ~evt_clr) | press;
  end

  // Plain writable registers: LED drive and interrupt enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      led <= '0;
      ien <= '0;
    end else begin
      if (wr_led) led <= wdata[LED_W-1:0];
      if (wr_ien) ien <= wdata[NBTN-1:0];
    end
  end

  assign leds = led;
  assign irq  = |(evt & ien);

  // Combinational read mux, zero-extended; unmapped indices read 0.
  always_comb begin
    rdata = '0;
    case (idx)
      3'd0:    rdata[SW_W-1:0]  = sw_s2;
      3'd1:    rdata[LED_W-1:0] = led;
      3'd2:    rdata[NBTN-1:0]  = ~st;
      3'd3:    rdata[NBTN-1:0]  = evt;
      3'd4:    rdata[NBTN-1:0]  = ien;
      default: rdata = '0;
    endcase
  end

endmodule
